// File: rtl/bbc_pkg.sv
// Shared types and constants for the BBC motherboard bus cycle sequencer.
package bbc_pkg;

  // Bus cycle sequencer states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_FALL = 3'd1,
    LATCH     = 3'd2,
    WAIT_RISE = 3'd3,
    HIGH      = 3'd4,
    DONE      = 3'd5
  } state_t;

  // Host-side register addresses handled by the address decoder
  localparam logic [15:0] ADR_ROM_SEL = 16'hFE30;
  localparam logic [15:0] ADR_SHADOW  = 16'hFE34;
  localparam logic [15:0] ADR_FE05    = 16'hFE05;

  // Width of the paged-ROM select register
  localparam int unsigned ROM_SEL_W = 4;

endpackage

// File: rtl/bbc_phi_sync.sv
// Synchronises the motherboard phi0 into the clk domain and produces
// one-clk rise/fall pulses from a single edge-detect flop.
module bbc_phi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phi0_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift phi0 through the synchroniser; prev holds the last synchronised value
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], phi0_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/bbc_cycle_seq.sv
// Sequences one slow motherboard bus cycle per off-board CPU access,
// aligned to phi0, with local copies of the paged-ROM/shadow registers.
module bbc_cycle_seq
  import bbc_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FE4X_EXTRA  = 1,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 resetb,
  input  logic                 bbc_phi0,
  input  logic                 cpu_req,
  input  logic                 cpu_rnw,
  input  logic [7:0]           cpu_data_i,
  input  logic                 dec_rom_reg,
  input  logic                 dec_shadow_reg,
  input  logic                 dec_fe4x,
  input  logic [7:0]           bbc_data_i,
  output logic                 lat_en,
  output logic                 bbc_rnw,
  output logic                 bbc_data_oe,
  output logic [7:0]           bbc_data_o,
  output logic                 cpu_rdy,
  output logic [7:0]           cpu_data_o,
  output logic [ROM_SEL_W-1:0] rom_sel_q,
  output logic                 shadow_q,
  output logic                 bus_err
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  localparam logic [3:0] EXTRA_N = 4'(FE4X_EXTRA);

  logic phi_rise, phi_fall;

  bbc_phi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_phi_sync (
    .clk    (clk),
    .rst_n  (resetb),
    .phi0_i (bbc_phi0),
    .rise_o (phi_rise),
    .fall_o (phi_fall)
  );

  state_t               state_q, state_d;
  logic                 rnw_q, rnw_d;
  logic                 rom_q, rom_d;
  logic                 shd_q, shd_d;
  logic                 fe4x_q, fe4x_d;
  logic [7:0]           data_q, data_d;
  logic [3:0]           extra_q, extra_d;
  logic [7:0]           to_cnt_q, to_cnt_d;
  logic                 abort_q, abort_d;
  logic                 lat_en_q, lat_en_d;
  logic                 bbc_rnw_q, bbc_rnw_d;
  logic                 oe_q, oe_d;
  logic [7:0]           bdo_q, bdo_d;
  logic                 rdy_q, rdy_d;
  logic [7:0]           cdo_q, cdo_d;
  logic [ROM_SEL_W-1:0] rsel_q, rsel_d;
  logic                 shadow_r_q, shadow_r_d;
  logic                 err_q, err_d;
  logic                 timeout;

  // Next-state, timeout and registered-output logic
  always_comb begin
    state_d    = state_q;
    rnw_d      = rnw_q;
    rom_d      = rom_q;
    shd_d      = shd_q;
    fe4x_d     = fe4x_q;
    data_d     = data_q;
    extra_d    = extra_q;
    abort_d    = abort_q;
    bbc_rnw_d  = bbc_rnw_q;
    oe_d       = oe_q;
    bdo_d      = bdo_q;
    cdo_d      = cdo_q;
    rsel_d     = rsel_q;
    shadow_r_d = shadow_r_q;
    lat_en_d   = 1'b0;
    rdy_d      = 1'b0;
    err_d      = 1'b0;

    if (phi_rise || phi_fall)
      to_cnt_d = '0;
    else if (state_q != IDLE && state_q != DONE)
      to_cnt_d = to_cnt_q + 8'd1;
    else
      to_cnt_d = to_cnt_q;

    timeout = (state_q inside {WAIT_FALL, LATCH, WAIT_RISE, HIGH}) &&
              !(phi_rise || phi_fall) && (to_cnt_q == TO_LAST);

    case (state_q)
      IDLE: begin
        // rdy_q high means this is the handshake clk; the request is stale
        if (cpu_req && !rdy_q) begin
          state_d  = WAIT_FALL;
          rnw_d    = cpu_rnw;
          rom_d    = dec_rom_reg;
          shd_d    = dec_shadow_reg;
          fe4x_d   = dec_fe4x;
          data_d   = cpu_data_i;
          extra_d  = '0;
          abort_d  = 1'b0;
          to_cnt_d = '0;
        end
      end
      WAIT_FALL: begin
        if (phi_fall) state_d = LATCH;
      end
      LATCH: begin
        lat_en_d  = 1'b1;
        bbc_rnw_d = rnw_q;
        if (!rnw_q) bdo_d = data_q;
        state_d   = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (phi_rise) begin
          state_d = HIGH;
          if (!rnw_q) oe_d = 1'b1;
        end
      end
      HIGH: begin
        if (phi_fall) begin
          if (fe4x_q && extra_q < EXTRA_N) begin
            extra_d = extra_q + 4'd1;
            state_d = WAIT_RISE;
          end else begin
            if (rnw_q) cdo_d = bbc_data_i;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rdy_d     = 1'b1;
        err_d     = abort_q;
        oe_d      = 1'b0;
        bbc_rnw_d = 1'b1;
        if (!abort_q && !rnw_q) begin
          if (rom_q) rsel_d     = data_q[ROM_SEL_W-1:0];
          if (shd_q) shadow_r_d = data_q[7];
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = DONE;
      cdo_d   = 8'hFF;
      abort_d = 1'b1;
      oe_d    = 1'b0;
    end
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      rnw_q      <= 1'b1;
      rom_q      <= 1'b0;
      shd_q      <= 1'b0;
      fe4x_q     <= 1'b0;
      data_q     <= '0;
      extra_q    <= '0;
      to_cnt_q   <= '0;
      abort_q    <= 1'b0;
      lat_en_q   <= 1'b0;
      bbc_rnw_q  <= 1'b1;
      oe_q       <= 1'b0;
      bdo_q      <= '0;
      rdy_q      <= 1'b0;
      cdo_q      <= '0;
      rsel_q     <= '0;
      shadow_r_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rnw_q      <= rnw_d;
      rom_q      <= rom_d;
      shd_q      <= shd_d;
      fe4x_q     <= fe4x_d;
      data_q     <= data_d;
      extra_q    <= extra_d;
      to_cnt_q   <= to_cnt_d;
      abort_q    <= abort_d;
      lat_en_q   <= lat_en_d;
      bbc_rnw_q  <= bbc_rnw_d;
      oe_q       <= oe_d;
      bdo_q      <= bdo_d;
      rdy_q      <= rdy_d;
      cdo_q      <= cdo_d;
      rsel_q     <= rsel_d;
      shadow_r_q <= shadow_r_d;
      err_q      <= err_d;
    end
  end

  assign lat_en      = lat_en_q;
  assign bbc_rnw     = bbc_rnw_q;
  assign bbc_data_oe = oe_q;
  assign bbc_data_o  = bdo_q;
  assign cpu_rdy     = rdy_q;
  assign cpu_data_o  = cdo_q;
  assign rom_sel_q   = rsel_q;
  assign shadow_q    = shadow_r_q;
  assign bus_err     = err_q;

endmodule
